// File: rtl/blk_mem_arbiter_pkg.sv
// Shared constants and in-flight read descriptor for the two-port block RAM arbiter.
package blk_mem_arbiter_pkg;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
    localparam int unsigned PIPE_DEPTH = 2;

    typedef struct packed {
        logic vld;
        logic port;
        logic err;
    } inflight_t;

endpackage

// File: rtl/blk_mem_gen_0.sv
// Two-cycle single-port block RAM: address registered, then output registered; advances only when ena=1.
module blk_mem_gen_0 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_SIZE   = 1024,
    parameter int unsigned AW         = $clog2(MEM_SIZE) + 1
) (
    input  logic                  clka,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [AW-1:0]         addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta
);

    localparam int unsigned IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [IW-1:0]         idx;
    logic                  in_range;

    assign idx      = addra[IW-1:0];
    assign in_range = addra < AW'(MEM_SIZE);

    always_comb begin
        rd_d   = rd_q;
        dout_d = dout_q;
        if (ena) begin
            rd_d   = in_range ? mem[idx] : '0;
            dout_d = rd_q;
        end
    end

    always_ff @(posedge clka) begin
        if (ena && wea && in_range) begin
            mem[idx] <= dina;
        end
        rd_q   <= rd_d;
        dout_q <= dout_d;
    end

    assign douta = dout_q;

endmodule

// File: rtl/blk_mem_arbiter.sv
// Round-robin arbiter sharing one two-cycle block RAM between ports A and B, with range checking and registered read responses.
module blk_mem_arbiter
    import blk_mem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_SIZE   = 1024,
    parameter int unsigned AW         = $clog2(MEM_SIZE) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [AW-1:0]         a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rerr,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [AW-1:0]         b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rerr
);

    logic                             rr_q, rr_d;
    inflight_t [PIPE_DEPTH-1:0]       pipe_q, pipe_d;
    inflight_t                        new_rd, last;
    logic                             grant_a, grant_b, accept;
    logic                             gnt_port, gnt_we, in_range;
    logic [AW-1:0]                    gnt_addr;
    logic [DATA_WIDTH-1:0]            gnt_wdata;
    logic                             mem_ena, mem_wea;
    logic [AW-1:0]                    mem_addr;
    logic [DATA_WIDTH-1:0]            mem_din, mem_dout;
    logic                             a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic                             a_rerr_q, a_rerr_d, b_rerr_q, b_rerr_d;
    logic [DATA_WIDTH-1:0]            a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    // Grant, pointer update and memory drive
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            grant_a = a_valid && (!b_valid || rr_q == PORT_A);
            grant_b = b_valid && (!a_valid || rr_q == PORT_B);
        end
        accept    = grant_a || grant_b;
        gnt_port  = grant_b ? PORT_B : PORT_A;
        gnt_we    = grant_b ? b_we : a_we;
        gnt_addr  = grant_b ? b_addr : a_addr;
        gnt_wdata = grant_b ? b_wdata : a_wdata;
        in_range  = gnt_addr < AW'(MEM_SIZE);

        rr_d = accept ? ~gnt_port : rr_q;

        new_rd.vld  = accept && !gnt_we;
        new_rd.port = gnt_port;
        new_rd.err  = !in_range;
        pipe_d      = {pipe_q[PIPE_DEPTH-2:0], new_rd};

        // Keep the RAM clocking while reads drain so their data reaches douta
        mem_ena  = accept || pipe_q[0].vld || pipe_q[1].vld;
        mem_wea  = accept && gnt_we && in_range;
        mem_addr = (accept && in_range) ? gnt_addr : '0;
        mem_din  = (accept && in_range) ? gnt_wdata : '0;
    end

    // Response capture from the oldest in-flight stage
    always_comb begin
        last       = pipe_q[PIPE_DEPTH-1];
        a_rvalid_d = last.vld && (last.port == PORT_A);
        b_rvalid_d = last.vld && (last.port == PORT_B);
        a_rdata_d  = a_rdata_q;
        a_rerr_d   = a_rerr_q;
        b_rdata_d  = b_rdata_q;
        b_rerr_d   = b_rerr_q;
        if (a_rvalid_d) begin
            a_rdata_d = last.err ? '0 : mem_dout;
            a_rerr_d  = last.err;
        end
        if (b_rvalid_d) begin
            b_rdata_d = last.err ? '0 : mem_dout;
            b_rerr_d  = last.err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q       <= PORT_A;
            pipe_q     <= '0;
            a_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            a_rerr_q   <= 1'b0;
            b_rvalid_q <= 1'b0;
            b_rdata_q  <= '0;
            b_rerr_q   <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            pipe_q     <= pipe_d;
            a_rvalid_q <= a_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            a_rerr_q   <= a_rerr_d;
            b_rvalid_q <= b_rvalid_d;
            b_rdata_q  <= b_rdata_d;
            b_rerr_q   <= b_rerr_d;
        end
    end

    blk_mem_gen_0 #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE),
        .AW         (AW)
    ) u_bram (
        .clka  (clk),
        .ena   (mem_ena),
        .wea   (mem_wea),
        .addra (mem_addr),
        .dina  (mem_din),
        .douta (mem_dout)
    );

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign a_rvalid = a_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign a_rerr   = a_rerr_q;
    assign b_rvalid = b_rvalid_q;
    assign b_rdata  = b_rdata_q;
    assign b_rerr   = b_rerr_q;

endmodule

// File: tb/tb_blk_mem_arbiter.sv
// Directed bench for blk_mem_arbiter: reset, write/read, round-robin, throughput, out-of-range and drain.
module tb_blk_mem_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned MS = 1024;
    localparam int unsigned AW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_ready, b_ready, a_rvalid, b_rvalid, a_rerr, b_rerr;
    logic [DW-1:0] a_rdata, b_rdata;

    typedef struct {
        int unsigned cyc;
        logic        port;
        logic [7:0]  data;
        logic        err;
    } rsp_t;

    rsp_t        rsp_q[$];
    int unsigned cyc = 0;
    int unsigned both_hi = 0;
    int          checks = 0;
    int          failures = 0;

    blk_mem_arbiter #(.DATA_WIDTH(DW), .MEM_SIZE(MS)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_rerr(a_rerr),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_rerr(b_rerr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response log, stamped with the number of the edge that produced it
    always @(negedge clk) begin
        if (a_rvalid) rsp_q.push_back('{cyc, 1'b0, a_rdata, a_rerr});
        if (b_rvalid) rsp_q.push_back('{cyc, 1'b1, b_rdata, b_rerr});
        if (a_rvalid && b_rvalid) both_hi <= both_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_we    = 1'b0;
        b_we    = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input int unsigned c, input logic p,
                              input logic [7:0] d, input logic e);
        rsp_t r;
        chk({tag, "_present"}, 32'(rsp_q.size() > 0), 32'd1);
        if (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            chk({tag, "_cyc"}, 32'(r.cyc), 32'(c));
            chk({tag, "_port"}, 32'(r.port), 32'(p));
            chk({tag, "_data"}, 32'(r.data), 32'(d));
            chk({tag, "_err"}, 32'(r.err), 32'(e));
        end
    endtask

    int unsigned acc, acc1, acc2;

    initial begin
        // Outputs during the power-on reset, with both requesters pushing
        a_valid = 1'b1;
        b_valid = 1'b1;
        step();
        step();
        chk("por_a_ready", 32'(a_ready), 32'd0);
        chk("por_b_ready", 32'(b_ready), 32'd0);
        chk("por_outs", 32'({a_rvalid, a_rerr, a_rdata, b_rvalid, b_rerr, b_rdata}), 32'd0);
        idle();
        rst = 1'b0;

        // Preload words 0..7 with 0x20+i through port A
        for (int i = 0; i < 8; i++) begin
            a_valid = 1'b1; a_we = 1'b1;
            a_addr  = AW'(i); a_wdata = DW'(8'h20 + i);
            #1;
            if (i == 0) chk("first_req_ready", 32'(a_ready), 32'd1);
            step();
        end
        idle();
        step();
        chk("writes_no_rsp", 32'(rsp_q.size()), 32'd0);

        // Read in flight when reset asserts is discarded
        a_valid = 1'b1; a_we = 1'b0; a_addr = AW'(5);
        #1;
        chk("rst_rd_ready", 32'(a_ready), 32'd1);
        step();
        idle();
        step();
        #2;
        rst     = 1'b1;
        a_valid = 1'b1;
        #1;
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_outs", 32'({a_rvalid, a_rerr, a_rdata, b_rvalid, b_rerr, b_rdata}), 32'd0);
        step();
        step();
        idle();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("rst_no_rvalid", 32'(rsp_q.size()), 32'd0);

        // Round-robin with both ports requesting for 4 cycles
        a_valid = 1'b1; a_we = 1'b0; a_addr = AW'(1);
        b_valid = 1'b1; b_we = 1'b0; b_addr = AW'(2);
        acc = 0;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk($sformatf("rr_a_ready%0d", j), 32'(a_ready), 32'((j % 2) == 0));
            chk($sformatf("rr_b_ready%0d", j), 32'(b_ready), 32'((j % 2) == 1));
            step();
            if (j == 0) acc = cyc;
        end
        idle();
        for (int i = 0; i < 5; i++) step();
        expect_rsp("rr0", acc + 2, 1'b0, 8'h21, 1'b0);
        expect_rsp("rr1", acc + 3, 1'b1, 8'h22, 1'b0);
        expect_rsp("rr2", acc + 4, 1'b0, 8'h21, 1'b0);
        expect_rsp("rr3", acc + 5, 1'b1, 8'h22, 1'b0);

        // Write then read on the next cycle
        a_valid = 1'b1; a_we = 1'b1; a_addr = AW'(3); a_wdata = 8'h10;
        step();
        a_we = 1'b0;
        #1;
        chk("wr_rd_ready", 32'(a_ready), 32'd1);
        step();
        acc = cyc;
        idle();
        for (int i = 0; i < 4; i++) step();
        expect_rsp("wr_rd", acc + 2, 1'b0, 8'h10, 1'b0);

        // Back-to-back reads from B
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            b_valid = 1'b1; b_we = 1'b0; b_addr = AW'(i);
            #1;
            chk($sformatf("b2b_ready%0d", i), 32'(b_ready), 32'd1);
            step();
            if (i == 0) acc = cyc;
        end
        idle();
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 8; i++) begin
            expect_rsp($sformatf("b2b%0d", i), acc + 2 + 32'(i), 1'b1,
                       (i == 3) ? 8'h10 : 8'(8'h20 + i), 1'b0);
        end

        // Out-of-range write dropped, read errors, word 0 untouched
        b_valid = 1'b1; b_we = 1'b1; b_addr = 11'h400; b_wdata = 8'hFF;
        #1;
        chk("oor_wr_ready", 32'(b_ready), 32'd1);
        step();
        b_we = 1'b0;
        step();
        acc1 = cyc;
        b_addr = 11'h000;
        step();
        acc2 = cyc;
        idle();
        for (int i = 0; i < 4; i++) step();
        expect_rsp("oor_rd", acc1 + 2, 1'b1, 8'h00, 1'b1);
        expect_rsp("oor_w0", acc2 + 2, 1'b1, 8'h20, 1'b0);
        chk("b_rdata_hold", 32'(b_rdata), 32'h20);

        // Pipeline drain after a lone read
        a_valid = 1'b1; a_we = 1'b0; a_addr = AW'(7);
        #1;
        chk("drain_ena_req", 32'(dut.mem_ena), 32'd1);
        step();
        acc = cyc;
        idle();
        chk("drain_ena1", 32'(dut.mem_ena), 32'd1);
        step();
        chk("drain_ena2", 32'(dut.mem_ena), 32'd1);
        step();
        chk("drain_ena_off", 32'(dut.mem_ena), 32'd0);
        chk("drain_rvalid", 32'(a_rvalid), 32'd1);
        chk("drain_rdata", 32'(a_rdata), 32'h27);
        step();
        chk("drain_rvalid_pulse", 32'(a_rvalid), 32'd0);
        chk("a_rdata_hold", 32'(a_rdata), 32'h27);
        expect_rsp("drain", acc + 2, 1'b0, 8'h27, 1'b0);

        step();
        chk("no_extra_rsp", 32'(rsp_q.size()), 32'd0);
        chk("never_both_rvalid", 32'(both_hi), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
